ysyx_220053_ifu: RTL and testbench

YSYX_220053_IFU -- requirements
Module: ysyx_220053_IFU

---
 rtl/ysyx_220053_ifu.sv | 77 +++++++
 tb/tb_ysyx_220053_ifu.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_220053_ifu.sv
// ysyx_220053_ifu: single-outstanding instruction fetch unit with redirect handling and RV64 I-type decode
module ysyx_220053_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [63:0] immI,
  output logic        wen,
  output logic        illegal,
  output logic [63:0] pc,
  input  logic        br_valid,
  input  logic [63:0] br_target
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  state_t      state, state_n;
  logic        drop, drop_n, latch;
  logic [63:0] fetch_pc;
  logic [31:0] inst;
  logic        op_imm;
  always_comb begin
    state_n = state;
    drop_n  = drop;
    latch   = 1'b0;
    case (state)
      S_REQ: if (imem_ready) begin
        state_n = S_WAIT;
        drop_n  = br_valid;
      end
      S_WAIT: if (imem_rvalid) begin
        // a redirect landing together with the response kills it just like a stale one
        state_n = (drop || br_valid) ? S_REQ : S_HOLD;
        latch   = !(drop || br_valid);
        drop_n  = 1'b0;
      end else if (br_valid) drop_n = 1'b1;
      S_HOLD: state_n = (br_valid || inst_ready) ? S_REQ : S_HOLD;
      default: state_n = S_REQ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      drop     <= 1'b0;
      fetch_pc <= RESET_PC;
      inst     <= 32'h0000_0013;
      pc       <= RESET_PC;
    end else begin
      state <= state_n;
      drop  <= drop_n;
      if (br_valid) fetch_pc <= {br_target[63:2], 2'b00};
      else if (state == S_HOLD && inst_ready) fetch_pc <= fetch_pc + 64'd4;
      if (latch) begin
        inst <= imem_rdata;
        pc   <= fetch_pc;
      end
    end
  end
  assign imem_req   = rst_n && state == S_REQ;
  assign imem_addr  = fetch_pc;
  assign inst_valid = state == S_HOLD;
  assign op_imm     = inst[6:0] == 7'b0010011;
  assign rd         = inst[11:7];
  assign rs1        = inst[19:15];
  assign rs2        = inst[24:20];
  assign immI       = {{52{inst[31]}}, inst[31:20]};
  assign illegal    = inst_valid && !op_imm;
  assign wen        = inst_valid && op_imm && inst[14:12] == 3'b000 && rd != 5'd0;
endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// tb_ysyx_220053_ifu: scoreboard bench for the fetch unit; expected decodes are queued when a response is driven
module tb_ysyx_220053_ifu;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [4:0]  rd, rs1, rs2;
  logic [63:0] immI, pc, br_target = 64'h0;
  logic        wen, illegal, br_valid = 1'b0;
  int          n_vec = 0, n_bad = 0;
  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm;
    logic        wen, ill;
  } exp_t;
  exp_t sb[$];
  ysyx_220053_ifu dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .rd(rd), .rs1(rs1), .rs2(rs2),
    .immI(immI), .wen(wen), .illegal(illegal), .pc(pc),
    .br_valid(br_valid), .br_target(br_target)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_req();
    int k = 0;
    while (!imem_req && k < 20) begin
      tick();
      k++;
    end
    if (!imem_req) chk("req_timeout", 64'd0, 64'd1);
  endtask
  task automatic fetch(input logic [31:0] w, input exp_t e);
    int k = 0;
    exp_t g;
    wait_req();
    chk("fetch_addr", imem_addr, e.pc);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("wait_no_req", {63'd0, imem_req}, 64'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = w;
    sb.push_back(e);
    tick();
    imem_rvalid = 1'b0;
    chk("latency2", {63'd0, inst_valid}, 64'd1);
    while (!inst_valid && k < 20) begin
      tick();
      k++;
    end
    if (!inst_valid) chk("valid_timeout", 64'd0, 64'd1);
    else if (sb.size() == 0) chk("sb_underflow", 64'd0, 64'd1);
    else begin
      g = sb.pop_front();
      chk("pc", pc, g.pc);
      chk("rd", {59'd0, rd}, {59'd0, g.rd});
      chk("rs1", {59'd0, rs1}, {59'd0, g.rs1});
      chk("rs2", {59'd0, rs2}, {59'd0, g.rs2});
      chk("immI", immI, g.imm);
      chk("wen", {63'd0, wen}, {63'd0, g.wen});
      chk("illegal", {63'd0, illegal}, {63'd0, g.ill});
    end
  endtask
  task automatic consume(input logic [63:0] next);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("post_consume_valid", {63'd0, inst_valid}, 64'd0);
    chk("post_consume_req", {63'd0, imem_req}, 64'd1);
    chk("post_consume_addr", imem_addr, next);
  endtask
  initial begin
    #2;
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_wen", {63'd0, wen}, 64'd0);
    chk("rst_ill", {63'd0, illegal}, 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("first_req", {63'd0, imem_req}, 64'd1);
    chk("first_addr", imem_addr, 64'h8000_0000);
    fetch(32'h0050_0093, '{64'h8000_0000, 5'd1, 5'd0, 5'd5, 64'd5, 1'b1, 1'b0});
    consume(64'h8000_0004);
    fetch(32'hFFF0_0113, '{64'h8000_0004, 5'd2, 5'd0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", {63'd0, inst_valid}, 64'd1);
      chk("hold_req", {63'd0, imem_req}, 64'd0);
      chk("hold_rd", {59'd0, rd}, 64'd2);
      chk("hold_imm", immI, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("hold_pc", pc, 64'h8000_0004);
    end
    consume(64'h8000_0008);
    chk("wait_addr", imem_addr, 64'h8000_0008);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    br_valid   = 1'b1;
    br_target  = 64'h8000_1002;
    tick();
    br_valid    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    tick();
    imem_rvalid = 1'b0;
    chk("drop_valid", {63'd0, inst_valid}, 64'd0);
    chk("drop_req", {63'd0, imem_req}, 64'd1);
    chk("drop_addr", imem_addr, 64'h8000_1000);
    tick();
    chk("drop_valid2", {63'd0, inst_valid}, 64'd0);
    fetch(32'h0000_0013, '{64'h8000_1000, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0});
    consume(64'h8000_1004);
    fetch(32'h0020_80B3, '{64'h8000_1004, 5'd1, 5'd1, 5'd2, 64'd2, 1'b0, 1'b1});
    br_valid   = 1'b1;
    br_target  = 64'h8000_2000;
    inst_ready = 1'b1;
    tick();
    br_valid   = 1'b0;
    inst_ready = 1'b0;
    chk("hold_br_valid", {63'd0, inst_valid}, 64'd0);
    chk("hold_br_addr", imem_addr, 64'h8000_2000);
    br_valid  = 1'b1;
    br_target = 64'h8000_3007;
    tick();
    br_valid = 1'b0;
    chk("req_br_req", {63'd0, imem_req}, 64'd1);
    chk("req_br_addr", imem_addr, 64'h8000_3004);
    imem_ready = 1'b1;
    br_valid   = 1'b1;
    br_target  = 64'h8000_4000;
    tick();
    imem_ready = 1'b0;
    br_valid   = 1'b0;
    chk("acc_br_req", {63'd0, imem_req}, 64'd0);
    imem_rvalid = 1'b1;
    tick();
    chk("acc_br_valid", {63'd0, inst_valid}, 64'd0);
    chk("acc_br_addr", imem_addr, 64'h8000_4000);
    tick();
    imem_rvalid = 1'b0;
    chk("stray_rvalid_req", {63'd0, imem_req}, 64'd1);
    chk("stray_rvalid_valid", {63'd0, inst_valid}, 64'd0);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", {63'd0, imem_req}, 64'd0);
    chk("async_rst_valid", {63'd0, inst_valid}, 64'd0);
    chk("async_rst_wen", {63'd0, wen}, 64'd0);
    tick();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    #1;
    chk("rerst_req", {63'd0, imem_req}, 64'd1);
    chk("rerst_addr", imem_addr, 64'h8000_0000);
    tick();
    imem_rvalid = 1'b0;
    chk("rerst_stray", {63'd0, inst_valid}, 64'd0);
    fetch(32'h0050_0093, '{64'h8000_0000, 5'd1, 5'd0, 5'd5, 64'd5, 1'b1, 1'b0});
    #2 rst_n = 1'b0;
    #1;
    chk("hold_rst_valid", {63'd0, inst_valid}, 64'd0);
    chk("hold_rst_wen", {63'd0, wen}, 64'd0);
    chk("hold_rst_pc", pc, 64'h8000_0000);
    tick();
    rst_n = 1'b1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
